// File: rtl/fft_chan_arbiter.sv
// Round-robin scheduler sharing one FFT engine among NUM_CH sample channels.
// Define FFT_ARB_TIMEOUT_EN to add a per-frame watchdog that aborts a stuck RUN after TIMEOUT cycles.
module fft_chan_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16384
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_done,
  input  logic                     eng_ready,
  output logic                     fft_start,
  output logic [DATA_W-1:0]        fft_data,
  input  logic                     fft_over,
  input  logic                     fft_data_vaild,
  output logic                     spec_vaild,
  output logic [CH_W-1:0]          spec_ch,
  output logic                     busy,
  output logic                     err_timeout
);

  typedef enum logic [2:0] {IDLE, ARB, START, RUN, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   win_id;
  logic              win_vld;
  logic [DATA_W-1:0] sel_data;
  logic              wd_hit;

  // Channel index base+off modulo NUM_CH; explicit so non-power-of-2 counts wrap correctly.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] id);
    logic [NUM_CH-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!win_vld && ch_req[wrap_add(rr_ptr, i)]) begin
        win_vld = 1'b1;
        win_id  = wrap_add(rr_ptr, i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == CH_W'(k)) sel_data = ch_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef FFT_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Cleared during START so the count is 0 in the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)                 wd_cnt <= '0;
    else if (state == START) wd_cnt <= '0;
    else if (state == RUN)   wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_hit = (state == RUN) && (wd_cnt == 16'(TIMEOUT - 1));
`else
  // Watchdog absent: this comparison is never true, RUN waits for fft_over indefinitely.
  assign wd_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      ch_grant    <= '0;
      ch_done     <= '0;
      fft_start   <= 1'b0;
      fft_data    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ch_done     <= '0;
      fft_start   <= 1'b0;
      err_timeout <= 1'b0;
      fft_data    <= (state == START || state == RUN) ? sel_data : '0;
      case (state)
        IDLE: begin
          if (|ch_req && eng_ready) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (win_vld) begin
            sel       <= win_id;
            ch_grant  <= ch_onehot(win_id);
            fft_start <= 1'b1;
            state     <= START;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (fft_over) begin
            ch_done <= ch_onehot(sel);
            state   <= DONE;
          end else if (wd_hit) begin
            ch_done     <= ch_onehot(sel);
            err_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          rr_ptr   <= wrap_add(sel, 1);
          ch_grant <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          ch_grant <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign spec_vaild = fft_data_vaild && (state == RUN);
  assign spec_ch    = sel;

endmodule

// File: tb/tb_fft_chan_arbiter.sv
// Bench for fft_chan_arbiter: hand table, corner sequences and random frames vs a round-robin model.
module tb_fft_chan_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_req;
  logic [31:0] ch_data;
  logic [3:0]  ch_grant;
  logic [3:0]  ch_done;
  logic        eng_ready;
  logic        fft_start;
  logic [7:0]  fft_data;
  logic        fft_over;
  logic        fft_data_vaild;
  logic        spec_vaild;
  logic [1:0]  spec_ch;
  logic        busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;
  int model_rr = 0;

`ifdef FFT_ARB_TIMEOUT_EN
  localparam int LONG_LAT = 50;
`else
  localparam int LONG_LAT = 100;
`endif

  fft_chan_arbiter #(.NUM_CH(4), .CH_W(2), .DATA_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data),
    .ch_grant(ch_grant), .ch_done(ch_done), .eng_ready(eng_ready),
    .fft_start(fft_start), .fft_data(fft_data), .fft_over(fft_over),
    .fft_data_vaild(fft_data_vaild), .spec_vaild(spec_vaild), .spec_ch(spec_ch),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] req_after;
    int         lat;
    int         exp_ch;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requesting channel at or after the pointer, searching upward with wrap.
  function automatic int model_pick(input logic [3:0] req, input int rr);
    for (int off = 0; off < 4; off++)
      if (req[(rr + off) % 4]) return (rr + off) % 4;
    return -1;
  endfunction

  task automatic wait_start(output logic got, output int waited);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 8) begin
      step();
      waited++;
      if (fft_start) got = 1'b1;
      else chk("pre_start_grant", ch_grant, 4'b0000);
    end
    chk("start_seen", got, 1'b1);
  endtask

  task automatic run_frame(input logic [3:0] req, input logic [3:0] req_after,
                           input int lat, input int exp_ch);
    logic       got;
    int         waited;
    logic [3:0] exp_gnt;
    logic [7:0] prev_slice;
    ch_req   = req;
    fft_over = 1'b0;
    wait_start(got, waited);
    if (!got) return;
    chk("start_latency", waited, 2);
    exp_gnt = 4'(1 << exp_ch);
    chk("grant_start", ch_grant, exp_gnt);
    chk("spec_ch_start", spec_ch, exp_ch);
    chk("busy_start", busy, 1'b1);
    chk("fft_data_start", fft_data, 8'h00);
    ch_req         = req_after;
    ch_data        = $urandom;
    fft_data_vaild = 1'($urandom);
    fft_over       = 1'($urandom);
    prev_slice     = ch_data[exp_ch*8 +: 8];
    #1 chk("spec_vaild_start", spec_vaild, 1'b0);
    for (int j = 1; j <= lat + 1; j++) begin
      step();
      chk("fft_data_track", fft_data, prev_slice);
      chk("grant_hold", ch_grant, exp_gnt);
      chk("spec_ch_hold", spec_ch, exp_ch);
      chk("busy_frame", busy, 1'b1);
      chk("fft_start_once", fft_start, 1'b0);
      chk("ch_done", ch_done, (j == lat + 1) ? exp_gnt : 4'b0000);
      chk("err_timeout_frame", err_timeout, 1'b0);
      ch_data        = $urandom;
      fft_data_vaild = 1'($urandom);
      fft_over       = (j == lat) ? 1'b1 : ((j == lat + 1) ? 1'($urandom) : 1'b0);
      prev_slice     = (j <= lat) ? ch_data[exp_ch*8 +: 8] : 8'h00;
      #1 chk("spec_vaild", spec_vaild, (j <= lat) ? fft_data_vaild : 1'b0);
    end
    step();
    chk("fft_data_idle", fft_data, prev_slice);
    chk("grant_drop", ch_grant, 4'b0000);
    chk("busy_idle", busy, 1'b0);
    chk("ch_done_once", ch_done, 4'b0000);
    fft_over = 1'b0;
    model_rr = (exp_ch + 1) % 4;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_grant"}, ch_grant, 4'b0000);
    chk({name, "_done"}, ch_done, 4'b0000);
    chk({name, "_start"}, fft_start, 1'b0);
    chk({name, "_data"}, fft_data, 8'h00);
    chk({name, "_spec_ch"}, spec_ch, 2'd0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_err"}, err_timeout, 1'b0);
  endtask

  initial begin
    logic       got;
    int         waited;
    int         ch;
    logic [3:0] r;
    tbl[0]  = '{4'b1111, 4'b1111, 5,        0};
    tbl[1]  = '{4'b1111, 4'b1111, 7,        1};
    tbl[2]  = '{4'b1111, 4'b1111, 3,        2};
    tbl[3]  = '{4'b1111, 4'b1111, 1,        3};
    tbl[4]  = '{4'b1111, 4'b1111, 4,        0};
    tbl[5]  = '{4'b0100, 4'b0100, LONG_LAT, 2};
    tbl[6]  = '{4'b0010, 4'b0000, 6,        1};
    tbl[7]  = '{4'b1001, 4'b1001, 2,        3};
    tbl[8]  = '{4'b1001, 4'b1001, 2,        0};
    tbl[9]  = '{4'b0001, 4'b0000, 3,        0};
    tbl[10] = '{4'b0110, 4'b0110, 8,        1};
    tbl[11] = '{4'b1010, 4'b1000, 2,        3};

    rst = 1'b1; ch_req = '0; ch_data = '0; eng_ready = 1'b1;
    fft_over = 1'b0; fft_data_vaild = 1'b1;
    step(); step();
    check_all_zero("reset");
    chk("reset_spec_vaild", spec_vaild, 1'b0);
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    for (int i = 0; i < 12; i++) begin
      chk("tbl_model", model_pick(tbl[i].req, model_rr), tbl[i].exp_ch);
      run_frame(tbl[i].req, tbl[i].req_after, tbl[i].lat, tbl[i].exp_ch);
    end

    // Engine not ready: requests must be ignored.
    eng_ready = 1'b0; ch_req = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("nr_grant", ch_grant, 4'b0000);
      chk("nr_start", fft_start, 1'b0);
      chk("nr_busy", busy, 1'b0);
    end
    eng_ready = 1'b1;
    run_frame(4'b0001, 4'b0001, 10, model_pick(4'b0001, model_rr));

    // Reset in the middle of RUN.
    ch_req = 4'b1111;
    wait_start(got, waited);
    chk("rst_pre_grant", ch_grant, 4'(1 << model_pick(4'b1111, model_rr)));
    step(); step(); step();
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b1; ch_req = 4'b0000; fft_over = 1'b0; fft_data_vaild = 1'b1;
    step();
    check_all_zero("mid_rst");
    chk("mid_rst_spec_vaild", spec_vaild, 1'b0);
    rst = 1'b0;
    model_rr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_done", ch_done, 4'b0000);
      chk("post_rst_start", fft_start, 1'b0);
    end
    run_frame(4'b1111, 4'b0000, 3, 0);

    // Random frames with idle gaps and stray fft_over outside RUN.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ch_req = 4'b0000; fft_over = 1'b1;
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          step();
          chk("gap_busy", busy, 1'b0);
          chk("gap_grant", ch_grant, 4'b0000);
        end
        fft_over = 1'b0;
      end
      r  = 4'($urandom_range(1, 15));
      ch = model_pick(r, model_rr);
      run_frame(r, 4'($urandom_range(0, 15)), $urandom_range(1, 20), ch);
    end

    // Engine that never reports completion.
    ch_req = 4'b0010; fft_over = 1'b0;
    ch = model_pick(4'b0010, model_rr);
    wait_start(got, waited);
    ch_req = 4'b0000;
`ifdef FFT_ARB_TIMEOUT_EN
    waited = 0; got = 1'b0;
    while (!got && waited < 200) begin
      step();
      waited++;
      if (err_timeout) got = 1'b1;
    end
    chk("timeout_delay", waited, 65);
    chk("timeout_done", ch_done, 4'(1 << ch));
    step();
    chk("timeout_pulse", err_timeout, 1'b0);
    chk("timeout_idle", busy, 1'b0);
    model_rr = (ch + 1) % 4;
    // fft_over in the same cycle as the timeout wins.
    ch_req = 4'b0100;
    ch = model_pick(4'b0100, model_rr);
    wait_start(got, waited);
    ch_req = 4'b0000;
    for (int i = 1; i <= 64; i++) begin
      step();
      fft_over = (i == 64);
    end
    step();
    fft_over = 1'b0;
    chk("race_done", ch_done, 4'(1 << ch));
    chk("race_err", err_timeout, 1'b0);
    model_rr = (ch + 1) % 4;
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("no_wd_err", err_timeout, 1'b0);
      chk("no_wd_busy", busy, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_rr = 0;
    check_all_zero("wd_recover");
`endif
    run_frame(4'b1111, 4'b0000, 2, model_pick(4'b1111, model_rr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_chan_arbiter.md
Name: fft_chan_arbiter

Overview:
- Round-robin scheduler that shares one FFT engine (start/over handshake, 8-bit sample input, spectrum-valid output) among NUM_CH sample channels.
- Arbitrates channel requests, grants one channel per FFT frame, and muxes that channel's samples into the engine.
- Issues the engine start pulse and waits for frame completion.
- Returns a per-channel done pulse and tags spectrum output with the channel id.
- Sits between the ADC channel front-ends and the FFT control block.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- CH_W, 2, width of channel id; must equal clog2(NUM_CH)
- DATA_W, 8, sample width per channel
- TIMEOUT, 16384, watchdog limit in clk cycles for one frame (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ch_req  in  NUM_CH  per-channel frame request, level
- ch_data  in  NUM_CH*DATA_W  packed channel samples; channel k at [k*DATA_W +: DATA_W]
- ch_grant  out  NUM_CH  one-hot grant, held for the whole frame
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel
- eng_ready  in  1  engine can accept a new frame
- fft_start  out  1  one-cycle start pulse to the engine
- fft_data  out  DATA_W  registered sample of the granted channel
- fft_over  in  1  engine frame-complete pulse
- fft_data_vaild  in  1  engine spectrum word valid
- spec_vaild  out  1  spectrum valid, qualified by active frame
- spec_ch  out  CH_W  channel id of the current spectrum
- busy  out  1  frame in progress (state != IDLE)
- err_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset values: every output is 0; rr pointer is 0; state is IDLE. Reset mid-frame aborts immediately: no ch_done, no fft_start.
- FSM states: IDLE, ARB, START, RUN, DONE.
- IDLE -> ARB when |ch_req && eng_ready. If eng_ready=0, stay in IDLE regardless of requests.
- ARB (1 cycle):
  - Winner is the first requesting channel at or after rr pointer, searching upward with wrap.
  - Winner id is latched into sel.
  - ch_grant[sel] asserts in the cycle after ARB and is held through DONE.
- START (1 cycle): fft_start=1. Next state is RUN.
- RUN:
  - Wait for fft_over.
  - fft_over in any state other than RUN is ignored.
- DONE (1 cycle):
  - ch_done[sel]=1.
  - rr pointer <= sel+1, wrapping NUM_CH-1 -> 0.
  - Next state is IDLE; grant drops the following cycle.
- Requests are sampled only in IDLE/ARB. Deasserting ch_req[sel] mid-frame does not abort the frame; ch_done still pulses.
- A channel re-requesting right after its done is served only after every other pending channel.
- Minimum IDLE-to-IDLE frame cost is 4 cycles plus the engine time.
- fft_data:
  - Registered each clk from ch_data slice sel while state is START or RUN, so output lags ch_data by 1 cycle.
  - 0 in all other states.
- spec_vaild = fft_data_vaild && state==RUN, combinational.
- spec_ch = sel, held from ARB+1 until the next ARB.
- busy = (state != IDLE), registered with state.
- Width rule: sel is CH_W bits. Non-power-of-2 NUM_CH wraps the pointer explicitly; it never relies on overflow.

Optional Feature:
- Macro: FFT_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entering RUN and increments each RUN cycle.
  - When the count reaches TIMEOUT-1 without fft_over: err_timeout pulses 1 cycle, FSM goes to DONE, and ch_done[sel] still pulses.
  - fft_over arriving in the same cycle as the timeout wins; err_timeout stays 0 in that case.
- Without the macro: no counter exists, err_timeout is tied to 0, and RUN waits indefinitely for fft_over.

Test Plan:
- Single request, NUM_CH=4: rst 1->0, ch_req=4'b0100, eng_ready=1, engine model asserts fft_over 100 cycles after fft_start -> ch_grant=4'b0100, one fft_start pulse, fft_data tracks ch_data[23:16] delayed 1 cycle, ch_done=4'b0100 exactly once, busy returns to 0.
- Round-robin fairness: ch_req=4'b1111 held for 5 frames -> grant order 0,1,2,3,0; spec_ch matches each grant.
- Engine not ready: eng_ready=0 with ch_req=4'b0001 for 50 cycles -> no grant, fft_start=0, busy=0; eng_ready 0->1 -> grant 4'b0001 within 2 cycles.
- Request drop mid-frame: ch_req[1] deasserted during RUN -> frame completes, ch_done[1] pulses, no other grant until DONE.
- Reset mid-RUN: rst=1 for 1 cycle during RUN -> all outputs 0 the next cycle, no ch_done, next grant starts from channel 0.
- FFT_ARB_TIMEOUT_EN defined, TIMEOUT=64, engine never asserts fft_over -> err_timeout pulses 64 cycles after RUN entry, ch_done[sel] pulses, FSM returns to IDLE. Build without the macro -> err_timeout stays 0 and busy stays 1.
